// File: rtl/ysyx_23060136_idu_issue_ctrl_pkg.sv
// Shared types and widths for the IDU issue controller slice.
package ysyx_23060136_idu_issue_ctrl_pkg;

    localparam int BITS_W         = 32;
    localparam int INST_W         = 32;
    localparam int GPR_W          = 5;
    localparam int NUM_GPR        = 32;
    localparam int PEND_W_DEF     = 2;
    localparam int CSR_PEND_W_DEF = 2;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        HALTED = 2'd2
    } issue_state_e;

endpackage

// File: rtl/ysyx_23060136_idu_issue_ctrl_scoreboard.sv
// GPR/CSR pending-writer scoreboard: one saturating-guarded counter per GPR plus one for CSRs.
module ysyx_23060136_IDU_SCOREBOARD
    import ysyx_23060136_idu_issue_ctrl_pkg::*;
#(
    parameter int PEND_W     = PEND_W_DEF,
    parameter int CSR_PEND_W = CSR_PEND_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc_en,
    input  logic [GPR_W-1:0] i_inc_rd,
    input  logic             i_dec_en,
    input  logic [GPR_W-1:0] i_dec_rd,
    input  logic             i_csr_inc,
    input  logic             i_csr_dec,
    input  logic [GPR_W-1:0] i_rs1,
    input  logic [GPR_W-1:0] i_rs2,
    input  logic [GPR_W-1:0] i_rd,
    output logic             o_rs1_busy,
    output logic             o_rs2_busy,
    output logic             o_rd_sat,
    output logic             o_csr_busy,
    output logic             o_csr_sat
);

    logic [PEND_W-1:0]     r_pend [NUM_GPR];
    logic [CSR_PEND_W-1:0] r_csr_pend;
    logic [NUM_GPR-1:0]    w_inc_vec;
    logic [NUM_GPR-1:0]    w_dec_vec;
    logic                  w_gpr_underflow;
    logic                  w_csr_underflow;

    // One-hot per-register increment/decrement requests; x0 never gets a request.
    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (i_inc_en && (i_inc_rd != '0)) w_inc_vec[i_inc_rd] = 1'b1;
        if (i_dec_en && (i_dec_rd != '0)) w_dec_vec[i_dec_rd] = 1'b1;
    end

    // GPR counters: simultaneous inc and dec cancel; a decrement at zero holds zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) r_pend[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_GPR; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i] && (r_pend[i] != '1))
                    r_pend[i] <= r_pend[i] + PEND_W'(1);
                else if (w_dec_vec[i] && !w_inc_vec[i] && (r_pend[i] != '0))
                    r_pend[i] <= r_pend[i] - PEND_W'(1);
            end
        end
    end

    // CSR counter: a retiring CSR instruction may pulse both write ports but counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csr_pend <= '0;
        end else if (i_csr_inc && !i_csr_dec && (r_csr_pend != '1)) begin
            r_csr_pend <= r_csr_pend + CSR_PEND_W'(1);
        end else if (i_csr_dec && !i_csr_inc && (r_csr_pend != '0)) begin
            r_csr_pend <= r_csr_pend - CSR_PEND_W'(1);
        end
    end

    assign o_rs1_busy = (i_rs1 != '0) && (r_pend[i_rs1] != '0);
    assign o_rs2_busy = (i_rs2 != '0) && (r_pend[i_rs2] != '0);
    assign o_rd_sat   = (i_rd != '0) && (r_pend[i_rd] == '1);
    assign o_csr_busy = (r_csr_pend != '0);
    assign o_csr_sat  = (r_csr_pend == '1);

    // A retire for a register with no pending writer means the WB side lost track.
    assign w_gpr_underflow = (w_dec_vec != '0) && !(w_inc_vec == w_dec_vec) && (r_pend[i_dec_rd] == '0);
    assign w_csr_underflow = i_csr_dec && !i_csr_inc && (r_csr_pend == '0);

    a_gpr_underflow: assert property (@(posedge clk) disable iff (rst) !w_gpr_underflow);
    a_csr_underflow: assert property (@(posedge clk) disable iff (rst) !w_csr_underflow);

endmodule

// File: rtl/ysyx_23060136_idu_issue_ctrl.sv
// Decode-stage issue controller: owns the IFU->IDU slot and stalls issue on RAW hazards.
module ysyx_23060136_idu_issue_ctrl
    import ysyx_23060136_idu_issue_ctrl_pkg::*;
#(
    parameter int PEND_W     = PEND_W_DEF,
    parameter int CSR_PEND_W = CSR_PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IFU_o_valid,
    input  logic [BITS_W-1:0] IFU_o_pc,
    input  logic [INST_W-1:0] IFU_o_inst,
    input  logic              IFU_o_commit,
    output logic              IDU_o_ready,
    output logic [BITS_W-1:0] IDU_i_pc,
    output logic [INST_W-1:0] IDU_i_inst,
    output logic              IDU_i_commit,
    input  logic [GPR_W-1:0]  dec_rs1,
    input  logic [GPR_W-1:0]  dec_rs2,
    input  logic [GPR_W-1:0]  dec_rd,
    input  logic              dec_write_gpr,
    input  logic              dec_write_csr,
    input  logic              dec_read_csr,
    input  logic              dec_halt,
    output logic              IDU_o_valid,
    input  logic              EXU_i_ready,
    output logic              IDU_o_issue,
    input  logic              flush,
    input  logic              WB_o_RegWr,
    input  logic [GPR_W-1:0]  WB_o_rd,
    input  logic              WB_o_CSRWr_1,
    input  logic              WB_o_CSRWr_2,
    output logic [31:0]       IDU_o_stall_cnt
);

    issue_state_e      r_state;
    logic [BITS_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_commit;
    logic [31:0]       r_stall_cnt;

    logic w_rs1_busy, w_rs2_busy, w_rd_sat, w_csr_busy, w_csr_sat;
    logic w_hazard, w_valid, w_issue, w_load;

    ysyx_23060136_IDU_SCOREBOARD #(
        .PEND_W     (PEND_W),
        .CSR_PEND_W (CSR_PEND_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_inc_en   (w_issue && dec_write_gpr),
        .i_inc_rd   (dec_rd),
        .i_dec_en   (WB_o_RegWr),
        .i_dec_rd   (WB_o_rd),
        .i_csr_inc  (w_issue && dec_write_csr),
        .i_csr_dec  (WB_o_CSRWr_1 || WB_o_CSRWr_2),
        .i_rs1      (dec_rs1),
        .i_rs2      (dec_rs2),
        .i_rd       (dec_rd),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy),
        .o_rd_sat   (w_rd_sat),
        .o_csr_busy (w_csr_busy),
        .o_csr_sat  (w_csr_sat)
    );

    assign w_hazard = w_rs1_busy || w_rs2_busy
                   || (dec_read_csr && w_csr_busy)
                   || (dec_write_gpr && w_rd_sat)
                   || (dec_write_csr && w_csr_sat);
    assign w_valid  = (r_state == FULL) && !w_hazard;
    assign w_issue  = w_valid && EXU_i_ready && !flush;
    assign w_load   = IFU_o_valid && !flush
                   && ((r_state == EMPTY) || (w_issue && !dec_halt));

    assign IDU_o_valid     = w_valid;
    assign IDU_o_issue     = w_issue;
    assign IDU_o_ready     = (r_state == EMPTY) || w_issue;
    assign IDU_i_pc        = r_pc;
    assign IDU_i_inst      = r_inst;
    assign IDU_i_commit    = r_commit;
    assign IDU_o_stall_cnt = r_stall_cnt;

    // Slot FSM: fill from IFU, drain on issue (reloading back-to-back), park forever after halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_pc     <= '0;
            r_inst   <= '0;
            r_commit <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_load) begin
                        r_state  <= FULL;
                        r_pc     <= IFU_o_pc;
                        r_inst   <= IFU_o_inst;
                        r_commit <= IFU_o_commit;
                    end
                end
                FULL: begin
                    if (flush) begin
                        r_state  <= EMPTY;
                        r_pc     <= '0;
                        r_inst   <= '0;
                        r_commit <= 1'b0;
                    end else if (w_issue) begin
                        if (dec_halt) begin
                            r_state <= HALTED;
                        end else if (w_load) begin
                            r_pc     <= IFU_o_pc;
                            r_inst   <= IFU_o_inst;
                            r_commit <= IFU_o_commit;
                        end else begin
                            r_state <= EMPTY;
                        end
                    end
                end
                HALTED:  r_state <= HALTED;
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Count cycles an instruction sits in the slot without leaving; saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == FULL) && !w_issue && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_idu_issue_ctrl.sv
// Directed bench for the IDU issue controller: handshake, RAW stalls, saturation, flush, halt, reset.
module tb_ysyx_23060136_idu_issue_ctrl;
    import ysyx_23060136_idu_issue_ctrl_pkg::*;

    logic              clk;
    logic              rst;
    logic              IFU_o_valid;
    logic [BITS_W-1:0] IFU_o_pc;
    logic [INST_W-1:0] IFU_o_inst;
    logic              IFU_o_commit;
    logic              IDU_o_ready;
    logic [BITS_W-1:0] IDU_i_pc;
    logic [INST_W-1:0] IDU_i_inst;
    logic              IDU_i_commit;
    logic [GPR_W-1:0]  dec_rs1, dec_rs2, dec_rd;
    logic              dec_write_gpr, dec_write_csr, dec_read_csr, dec_halt;
    logic              IDU_o_valid;
    logic              EXU_i_ready;
    logic              IDU_o_issue;
    logic              flush;
    logic              WB_o_RegWr;
    logic [GPR_W-1:0]  WB_o_rd;
    logic              WB_o_CSRWr_1, WB_o_CSRWr_2;
    logic [31:0]       IDU_o_stall_cnt;

    int checks   = 0;
    int failures = 0;

    ysyx_23060136_idu_issue_ctrl #(.PEND_W(2), .CSR_PEND_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .IFU_o_valid     (IFU_o_valid),
        .IFU_o_pc        (IFU_o_pc),
        .IFU_o_inst      (IFU_o_inst),
        .IFU_o_commit    (IFU_o_commit),
        .IDU_o_ready     (IDU_o_ready),
        .IDU_i_pc        (IDU_i_pc),
        .IDU_i_inst      (IDU_i_inst),
        .IDU_i_commit    (IDU_i_commit),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_rd          (dec_rd),
        .dec_write_gpr   (dec_write_gpr),
        .dec_write_csr   (dec_write_csr),
        .dec_read_csr    (dec_read_csr),
        .dec_halt        (dec_halt),
        .IDU_o_valid     (IDU_o_valid),
        .EXU_i_ready     (EXU_i_ready),
        .IDU_o_issue     (IDU_o_issue),
        .flush           (flush),
        .WB_o_RegWr      (WB_o_RegWr),
        .WB_o_rd         (WB_o_rd),
        .WB_o_CSRWr_1    (WB_o_CSRWr_1),
        .WB_o_CSRWr_2    (WB_o_CSRWr_2),
        .IDU_o_stall_cnt (IDU_o_stall_cnt)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        dec_write_gpr = 1'b0; dec_write_csr = 1'b0; dec_read_csr = 1'b0; dec_halt = 1'b0;
    endtask

    task automatic set_dec(input logic [GPR_W-1:0] rs1, input logic [GPR_W-1:0] rs2,
                           input logic [GPR_W-1:0] rd, input logic wg, input logic wc,
                           input logic rc, input logic h);
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        dec_write_gpr = wg; dec_write_csr = wc; dec_read_csr = rc; dec_halt = h;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic c);
        IFU_o_valid = 1'b1; IFU_o_pc = pc; IFU_o_inst = inst; IFU_o_commit = c;
    endtask

    task automatic no_offer();
        IFU_o_valid = 1'b0; IFU_o_pc = '0; IFU_o_inst = '0; IFU_o_commit = 1'b0;
    endtask

    task automatic wb_gpr(input logic en, input logic [GPR_W-1:0] rd);
        WB_o_RegWr = en; WB_o_rd = rd;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (IDU_o_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", IDU_o_ready); end
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", IDU_o_valid); end
        checks++; if (IDU_o_issue !== 1'b0) begin failures++; $display("[TB] FAIL reset_issue got=%0b exp=0", IDU_o_issue); end
        checks++; if (IDU_i_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=0", IDU_i_pc); end
        checks++; if (IDU_i_inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=0", IDU_i_inst); end
        checks++; if (IDU_i_commit !== 1'b0) begin failures++; $display("[TB] FAIL reset_commit got=%0b exp=0", IDU_i_commit); end
        checks++; if (IDU_o_stall_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_stall got=%0d exp=0", IDU_o_stall_cnt); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        EXU_i_ready = 1'b1;
        clear_dec();
        offer(32'h100, 32'h00100093, 1'b1);
        @(negedge clk);
        checks++; if (IDU_o_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_empty_ready got=%0b exp=1", IDU_o_ready); end
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_empty_valid got=%0b exp=0", IDU_o_valid); end
        tick();
        set_dec(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h104, 32'h00200113, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL stream_issue1 got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_i_pc !== 32'h100) begin failures++; $display("[TB] FAIL stream_pc1 got=%h exp=100", IDU_i_pc); end
        checks++; if (IDU_i_commit !== 1'b1) begin failures++; $display("[TB] FAIL stream_commit1 got=%0b exp=1", IDU_i_commit); end
        tick();
        set_dec(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h108, 32'h006201b3, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL stream_issue2 got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_i_pc !== 32'h104) begin failures++; $display("[TB] FAIL stream_pc2 got=%h exp=104", IDU_i_pc); end
        tick();
        set_dec(5'd4, 5'd6, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL stream_issue3 got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_i_inst !== 32'h006201b3) begin failures++; $display("[TB] FAIL stream_inst3 got=%h exp=006201b3", IDU_i_inst); end
        tick();
        clear_dec();
        wb_gpr(1'b1, 5'd1);
        @(negedge clk);
        checks++; if (IDU_o_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_drained_ready got=%0b exp=1", IDU_o_ready); end
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drained_valid got=%0b exp=0", IDU_o_valid); end
        checks++; if (IDU_o_stall_cnt !== 32'd0) begin failures++; $display("[TB] FAIL stream_stall got=%0d exp=0", IDU_o_stall_cnt); end
        tick();
        wb_gpr(1'b1, 5'd2);
        tick();
        wb_gpr(1'b1, 5'd3);
        tick();
        wb_gpr(1'b0, 5'd0);
    endtask

    task automatic test_raw();
        offer(32'h200, 32'h00500293, 1'b0);
        tick();
        set_dec(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h204, 32'h00128313, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL raw_writer_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        set_dec(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL raw_stall1_valid got=%0b exp=0", IDU_o_valid); end
        checks++; if (IDU_o_issue !== 1'b0) begin failures++; $display("[TB] FAIL raw_stall1_issue got=%0b exp=0", IDU_o_issue); end
        checks++; if (IDU_o_ready !== 1'b0) begin failures++; $display("[TB] FAIL raw_stall1_ready got=%0b exp=0", IDU_o_ready); end
        tick();
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL raw_stall2_valid got=%0b exp=0", IDU_o_valid); end
        checks++; if (IDU_o_stall_cnt !== 32'd1) begin failures++; $display("[TB] FAIL raw_stall2_cnt got=%0d exp=1", IDU_o_stall_cnt); end
        tick();
        wb_gpr(1'b1, 5'd5);
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL raw_wb_cycle_valid got=%0b exp=0", IDU_o_valid); end
        checks++; if (IDU_o_stall_cnt !== 32'd2) begin failures++; $display("[TB] FAIL raw_wb_cycle_cnt got=%0d exp=2", IDU_o_stall_cnt); end
        tick();
        wb_gpr(1'b0, 5'd0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL raw_release_issue got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_o_stall_cnt !== 32'd3) begin failures++; $display("[TB] FAIL raw_release_cnt got=%0d exp=3", IDU_o_stall_cnt); end
        tick();
        clear_dec();
        wb_gpr(1'b1, 5'd6);
        @(negedge clk);
        checks++; if (IDU_o_stall_cnt !== 32'd3) begin failures++; $display("[TB] FAIL raw_empty_cnt got=%0d exp=3", IDU_o_stall_cnt); end
        tick();
        wb_gpr(1'b0, 5'd0);
    endtask

    task automatic test_saturate();
        offer(32'h300, 32'h00100393, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_dec(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
            offer(32'h304 + 32'(4 * k), 32'h00138393, 1'b0);
            @(negedge clk);
            checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL sat_writer%0d_issue got=%0b exp=1", k, IDU_o_issue); end
            tick();
        end
        set_dec(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_fourth_valid got=%0b exp=0", IDU_o_valid); end
        tick();
        wb_gpr(1'b1, 5'd7);
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_wb_cycle_valid got=%0b exp=0", IDU_o_valid); end
        tick();
        wb_gpr(1'b0, 5'd0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL sat_release_issue got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_i_pc !== 32'h30c) begin failures++; $display("[TB] FAIL sat_release_pc got=%h exp=30c", IDU_i_pc); end
        checks++; if (IDU_o_stall_cnt !== 32'd5) begin failures++; $display("[TB] FAIL sat_cnt got=%0d exp=5", IDU_o_stall_cnt); end
        tick();
        clear_dec();
        for (int k = 0; k < 3; k++) begin
            wb_gpr(1'b1, 5'd7);
            tick();
        end
        wb_gpr(1'b0, 5'd0);
    endtask

    task automatic test_same_cycle();
        offer(32'h400, 32'h00100493, 1'b0);
        tick();
        set_dec(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h404, 32'h00148493, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL same_w1_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        set_dec(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h408, 32'h00900033, 1'b0);
        wb_gpr(1'b1, 5'd9);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL same_w2_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        set_dec(5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        no_offer();
        wb_gpr(1'b0, 5'd0);
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL same_reader_still_pending got=%0b exp=0", IDU_o_valid); end
        tick();
        wb_gpr(1'b1, 5'd9);
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL same_reader_wb_cycle got=%0b exp=0", IDU_o_valid); end
        tick();
        wb_gpr(1'b0, 5'd0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL same_reader_issue got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_o_stall_cnt !== 32'd7) begin failures++; $display("[TB] FAIL same_cnt got=%0d exp=7", IDU_o_stall_cnt); end
        tick();
        clear_dec();
    endtask

    task automatic test_csr();
        offer(32'h500, 32'h30529073, 1'b0);
        tick();
        set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        offer(32'h504, 32'h34129073, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL csr_w1_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        offer(32'h508, 32'h30502573, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL csr_w2_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        no_offer();
        WB_o_CSRWr_1 = 1'b1; WB_o_CSRWr_2 = 1'b1;
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL csr_read_pend2 got=%0b exp=0", IDU_o_valid); end
        tick();
        WB_o_CSRWr_1 = 1'b0; WB_o_CSRWr_2 = 1'b0;
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL csr_dual_pulse_once got=%0b exp=0", IDU_o_valid); end
        tick();
        WB_o_CSRWr_2 = 1'b1;
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL csr_read_wb_cycle got=%0b exp=0", IDU_o_valid); end
        tick();
        WB_o_CSRWr_2 = 1'b0;
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL csr_read_issue got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_o_stall_cnt !== 32'd10) begin failures++; $display("[TB] FAIL csr_cnt got=%0d exp=10", IDU_o_stall_cnt); end
        tick();
        clear_dec();
    endtask

    task automatic test_flush();
        offer(32'h600, 32'h00100513, 1'b0);
        tick();
        set_dec(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h604, 32'h00150513, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b0) begin failures++; $display("[TB] FAIL flush_issue got=%0b exp=0", IDU_o_issue); end
        checks++; if (IDU_o_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready got=%0b exp=0", IDU_o_ready); end
        tick();
        flush = 1'b0;
        no_offer();
        clear_dec();
        @(negedge clk);
        checks++; if (IDU_o_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty_ready got=%0b exp=1", IDU_o_ready); end
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_offer_dropped got=%0b exp=0", IDU_o_valid); end
        tick();
        offer(32'h608, 32'h00050593, 1'b0);
        tick();
        set_dec(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL flush_sb_untouched got=%0b exp=1", IDU_o_issue); end
        checks++; if (IDU_i_pc !== 32'h608) begin failures++; $display("[TB] FAIL flush_reload_pc got=%h exp=608", IDU_i_pc); end
        tick();
        clear_dec();
    endtask

    task automatic test_halt();
        offer(32'h700, 32'h00100073, 1'b0);
        tick();
        set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        offer(32'h704, 32'h00000013, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL halt_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        clear_dec();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (IDU_o_ready !== 1'b0) begin failures++; $display("[TB] FAIL halted%0d_ready got=%0b exp=0", k, IDU_o_ready); end
            checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL halted%0d_valid got=%0b exp=0", k, IDU_o_valid); end
            tick();
        end
        rst = 1'b1;
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_ready !== 1'b1) begin failures++; $display("[TB] FAIL halt_rst_ready got=%0b exp=1", IDU_o_ready); end
        checks++; if (IDU_i_pc !== 32'h0) begin failures++; $display("[TB] FAIL halt_rst_pc got=%h exp=0", IDU_i_pc); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        offer(32'h800, 32'h00100593, 1'b0);
        tick();
        set_dec(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        offer(32'h804, 32'h00058613, 1'b0);
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL mid_writer_issue got=%0b exp=1", IDU_o_issue); end
        tick();
        set_dec(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_stall_valid got=%0b exp=0", IDU_o_valid); end
        tick();
        @(negedge clk);
        checks++; if (IDU_o_stall_cnt !== 32'd1) begin failures++; $display("[TB] FAIL mid_stall_cnt got=%0d exp=1", IDU_o_stall_cnt); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (IDU_o_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_ready got=%0b exp=1", IDU_o_ready); end
        checks++; if (IDU_o_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got=%0b exp=0", IDU_o_valid); end
        checks++; if (IDU_o_issue !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_issue got=%0b exp=0", IDU_o_issue); end
        checks++; if (IDU_i_pc !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_pc got=%h exp=0", IDU_i_pc); end
        checks++; if (IDU_i_inst !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_inst got=%h exp=0", IDU_i_inst); end
        checks++; if (IDU_o_stall_cnt !== 32'd0) begin failures++; $display("[TB] FAIL mid_rst_cnt got=%0d exp=0", IDU_o_stall_cnt); end
        tick();
        rst = 1'b0;
        clear_dec();
        offer(32'h808, 32'h00058613, 1'b0);
        tick();
        set_dec(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        no_offer();
        @(negedge clk);
        checks++; if (IDU_o_issue !== 1'b1) begin failures++; $display("[TB] FAIL mid_counts_discarded got=%0b exp=1", IDU_o_issue); end
        tick();
        clear_dec();
    endtask

    // Run every scenario in order from reset, then report.
    initial begin
        rst = 1'b1;
        flush = 1'b0;
        EXU_i_ready = 1'b0;
        WB_o_CSRWr_1 = 1'b0;
        WB_o_CSRWr_2 = 1'b0;
        wb_gpr(1'b0, 5'd0);
        no_offer();
        clear_dec();
        test_reset();
        test_stream();
        test_raw();
        test_saturate();
        test_same_cycle();
        test_csr();
        test_flush();
        test_halt();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
